// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up/down counter with count enable, synchronous
// clear and load, and registered one-cycle wrap/error pulses. A chain of these
// forms a time-of-day datapath: each stage's carry_out drives the next
// stage's en, and all stages run on the same tick clock.
module mod_counter #(
  parameter int MODULUS   = 60,
  parameter int WIDTH     = 6,
  parameter int RESET_VAL = 0
) (
  input  logic             tick,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             load_err
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (MODULUS < 2) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be at least 2");
  end

  if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
    $error("mod_counter: WIDTH too narrow to hold MODULUS-1");
  end

  if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
    $error("mod_counter: RESET_VAL must lie in 0..MODULUS-1");
  end

  // ---------------------------------------------------------------------------
  // Constants, all sized to the count width
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] ZERO_VAL  = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VAL);
  // One extra bit so the range check also works when 2**WIDTH == MODULUS.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  // Per-edge action after priority resolution (clr > load > en > hold).
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2,
    ACT_CLR  = 2'd3
  } action_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True when v is a legal count value (0..MODULUS-1).
  function automatic logic in_range(input logic [WIDTH-1:0] v);
    return ({1'b0, v} < MOD_EXT);
  endfunction

  // Next value when counting up, wrapping MODULUS-1 -> 0.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == MAX_VAL) begin
      r = ZERO_VAL;
    end else begin
      r = v + ONE_VAL;
    end
    return r;
  endfunction

  // Next value when counting down, wrapping 0 -> MODULUS-1.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == ZERO_VAL) begin
      r = MAX_VAL;
    end else begin
      r = v - ONE_VAL;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_r;
  logic             carry_r;
  logic             borrow_r;
  logic             load_err_r;

  action_t          action_s;
  logic             load_ok_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             carry_nxt_s;
  logic             borrow_nxt_s;
  logic             load_err_nxt_s;

  // Resolve the control inputs into one action; lower-priority requests drop.
  always_comb begin
    action_s = ACT_HOLD;
    if (clr) begin
      action_s = ACT_CLR;
    end else if (load) begin
      action_s = ACT_LOAD;
    end else if (en) begin
      action_s = ACT_STEP;
    end else begin
      action_s = ACT_HOLD;
    end
  end

  // Only in-range load values are accepted; others flag load_err instead.
  always_comb begin
    load_ok_s = in_range(load_val);
  end

  // Next count and pulse values; pulses default low so each lasts one cycle.
  always_comb begin
    count_nxt_s    = count_r;
    carry_nxt_s    = 1'b0;
    borrow_nxt_s   = 1'b0;
    load_err_nxt_s = 1'b0;
    case (action_s)
      ACT_CLR: begin
        count_nxt_s = ZERO_VAL;
      end
      ACT_LOAD: begin
        if (load_ok_s) begin
          count_nxt_s = load_val;
        end else begin
          count_nxt_s    = count_r;
          load_err_nxt_s = 1'b1;
        end
      end
      ACT_STEP: begin
        if (up_dn) begin
          count_nxt_s = step_up(count_r);
          carry_nxt_s = (count_r == MAX_VAL);
        end else begin
          count_nxt_s  = step_down(count_r);
          borrow_nxt_s = (count_r == ZERO_VAL);
        end
      end
      ACT_HOLD: begin
        count_nxt_s = count_r;
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Count and pulse registers; async reset clears any pending pulse at once.
  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      count_r    <= RST_VAL;
      carry_r    <= 1'b0;
      borrow_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      carry_r    <= carry_nxt_s;
      borrow_r   <= borrow_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  // Outputs come straight from registers.
  assign count      = count_r;
  assign carry_out  = carry_r;
  assign borrow_out = borrow_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_mod_counter.sv
// Testbench for mod_counter: directed scenarios plus randomized traffic,
// checked through a queue-based scoreboard against a behavioural model,
// and a three-stage hh:mm:ss cascade checked edge by edge.
module tb_mod_counter;

  localparam int MOD = 60;
  localparam int W   = 6;

  logic         tick;
  logic         reset_n;
  logic         en, up_dn, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         carry_out, borrow_out, load_err;

  // cascade signals
  logic         c_en, c_load;
  logic [5:0]   s_cnt, m_cnt;
  logic [4:0]   h_cnt;
  logic         s_c, s_b, s_e, m_c, m_b, m_e, h_c, h_b, h_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {count, carry, borrow, load_err} per edge
  logic [W+2:0] sb[$];

  // Reference model state
  int  m_val;

  mod_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) dut (
    .tick(tick), .reset_n(reset_n), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .count(count), .carry_out(carry_out),
    .borrow_out(borrow_out), .load_err(load_err)
  );

  mod_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) u_sec (
    .tick(tick), .reset_n(reset_n), .en(c_en), .up_dn(1'b1), .clr(1'b0),
    .load(c_load), .load_val(6'd59), .count(s_cnt), .carry_out(s_c),
    .borrow_out(s_b), .load_err(s_e)
  );

  mod_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) u_min (
    .tick(tick), .reset_n(reset_n), .en(s_c), .up_dn(1'b1), .clr(1'b0),
    .load(c_load), .load_val(6'd59), .count(m_cnt), .carry_out(m_c),
    .borrow_out(m_b), .load_err(m_e)
  );

  mod_counter #(.MODULUS(24), .WIDTH(5), .RESET_VAL(0)) u_hr (
    .tick(tick), .reset_n(reset_n), .en(m_c), .up_dn(1'b1), .clr(1'b0),
    .load(c_load), .load_val(5'd23), .count(h_cnt), .carry_out(h_c),
    .borrow_out(h_b), .load_err(h_e)
  );

  initial tick = 1'b0;
  always #5 tick = ~tick;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge worth of inputs and push the model's expected result.
  task automatic step(input bit en_v, input bit up_v, input bit clr_v,
                      input bit ld_v, input int lv);
    bit c, b, e;
    @(negedge tick);
    en = en_v; up_dn = up_v; clr = clr_v; load = ld_v;
    load_val = W'(lv);
    c = 1'b0; b = 1'b0; e = 1'b0;
    if (clr_v) begin
      m_val = 0;
    end else if (ld_v) begin
      if (lv < MOD) m_val = lv;
      else e = 1'b1;
    end else if (en_v) begin
      if (up_v) begin
        if (m_val + 1 == MOD) c = 1'b1;
        m_val = (m_val + 1) % MOD;
      end else begin
        if (m_val == 0) b = 1'b1;
        m_val = (m_val + MOD - 1) % MOD;
      end
    end
    sb.push_back({W'(m_val), c, b, e});
  endtask

  task automatic idle_inputs();
    en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    logic [W+2:0] exp_v;
    forever begin
      @(posedge tick);
      #1;
      if (reset_n && sb.size() > 0) begin
        exp_v = sb.pop_front();
        chk("count",      int'(count),      int'(exp_v[W+2:3]));
        chk("carry_out",  int'(carry_out),  int'(exp_v[2]));
        chk("borrow_out", int'(borrow_out), int'(exp_v[1]));
        chk("load_err",   int'(load_err),   int'(exp_v[0]));
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    c_en = 1'b0; c_load = 1'b0;
    reset_n = 1'b0;
    m_val = 0;
    #12;
    chk("reset_count", int'(count), 0);
    chk("reset_carry", int'(carry_out), 0);
    chk("reset_borrow", int'(borrow_out), 0);
    chk("reset_err", int'(load_err), 0);
    @(negedge tick);
    reset_n = 1'b1;

    // Async reset mid-count at 37, no tick edge needed
    step(0, 0, 0, 1, 36);
    step(1, 1, 0, 0, 0);
    @(posedge tick); #2;
    idle_inputs();
    chk("pre_reset_count", int'(count), 37);
    reset_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    m_val = 0;
    @(negedge tick); reset_n = 1'b1;

    // Async reset clears a pending carry pulse
    step(0, 0, 0, 1, 59);
    step(1, 1, 0, 0, 0);
    @(posedge tick); #2;
    idle_inputs();
    chk("pulse_before_reset", int'(carry_out), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_carry", int'(carry_out), 0);
    chk("async_reset_count0", int'(count), 0);
    m_val = 0;
    @(negedge tick); reset_n = 1'b1;

    // Up wrap: 61 edges from 0, then one more
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 62; i++) step(1, 1, 0, 0, 0);

    // Down wrap from 2
    step(0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

    // Load / error / clr priority
    step(0, 0, 0, 1, 45);
    step(0, 0, 0, 1, 60);
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 63);

    // Priority over en at boundary, then hold
    step(0, 0, 0, 1, 59);
    step(1, 1, 0, 1, 10);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);

    // Direction reversal at boundaries
    step(0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 63)));
    end
    @(negedge tick);
    idle_inputs();
    @(posedge tick); #2;
    chk("scoreboard_drained", sb.size(), 0);

    // Cascade hh:mm:ss from 23:59:59
    @(negedge tick); c_load = 1'b1;
    @(negedge tick); c_load = 1'b0; c_en = 1'b1;
    @(posedge tick); #1;
    chk("casc_e1_sec", int'(s_cnt), 0);
    chk("casc_e1_sec_c", int'(s_c), 1);
    chk("casc_e1_min", int'(m_cnt), 59);
    chk("casc_e1_hr", int'(h_cnt), 23);
    @(negedge tick); c_en = 1'b0;
    @(posedge tick); #1;
    chk("casc_e2_sec_c", int'(s_c), 0);
    chk("casc_e2_min", int'(m_cnt), 0);
    chk("casc_e2_min_c", int'(m_c), 1);
    chk("casc_e2_hr", int'(h_cnt), 23);
    chk("casc_e2_sec", int'(s_cnt), 0);
    @(posedge tick); #1;
    chk("casc_e3_min_c", int'(m_c), 0);
    chk("casc_e3_hr", int'(h_cnt), 0);
    chk("casc_e3_hr_c", int'(h_c), 1);
    chk("casc_e3_hr_b", int'(h_b), 0);
    @(posedge tick); #1;
    chk("casc_e4_hr_c", int'(h_c), 0);
    chk("casc_e4_hr", int'(h_cnt), 0);
    chk("casc_e4_min", int'(m_cnt), 0);
    chk("casc_e4_sec", int'(s_cnt), 0);
    chk("casc_errs", int'({s_e, m_e, h_e, s_b, m_b}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
